led_row_scan: RTL and testbench
===============================

LED_ROW_SCAN -- requirements
Module: led_row_scan

Interface
REQ-001 The block SHALL have parameter ROWS, default 8, meaning the number of matrix rows scanned; legal range 2..16.
REQ-002 The block SHALL have parameter DWELL_CYC, default 1000, meaning the clock cycles each row is driven; legal minimum 1.
REQ-003 The block SHALL have parameter BLANK_CYC, default 16, meaning the clock cycles all rows are off before each row is driven; legal minimum 1.
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 0, meaning row_onehot_o polarity: 0 = active-high, 1 = active-low.
REQ-005 The block SHALL derive localparam ROW_W = clog2(ROWS), and SHALL NOT expose it as a port-level override.
REQ-006 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-007 rst_i  input  1  reset, synchronous, active-high.
REQ-008 scan_en_i  input  1  scan enable; 1 = run the scan, 0 = stop and hold all rows off.
REQ-009 row_sel_o  output  ROW_W  binary index of the current row.
REQ-010 row_onehot_o  output  ROWS  decoded row drive; exactly one bit active in DRIVE, none active otherwise, polarity per ACTIVE_LOW.
REQ-011 blank_o  output  1  1 whenever no row is driven.
REQ-012 row_load_o  output  1  one-cycle pulse on the first BLANK cycle of each row; column data for row_sel_o is latched on this pulse.
REQ-013 frame_start_o  output  1  one-cycle pulse coincident with row_load_o when row_sel_o = 0.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, BLANK and DRIVE.
REQ-015 All outputs SHALL be registered, and outputs in a given cycle SHALL reflect the current state, row and counter.
REQ-016 IDLE: with scan_en_i=1 sampled, the next cycle SHALL be BLANK with row_sel_o=0, row_load_o=1 and frame_start_o=1.
REQ-017 IDLE: with scan_en_i=0 sampled, the block SHALL remain in IDLE.
REQ-018 BLANK SHALL last exactly BLANK_CYC cycles with blank_o=1 and all row_onehot_o bits inactive, then go to DRIVE.
REQ-019 DRIVE SHALL last exactly DWELL_CYC cycles with blank_o=0 and row_onehot_o bit [row_sel_o] active, all other bits inactive.
REQ-020 At the end of DRIVE the block SHALL enter BLANK with row_sel_o incremented and pulse row_load_o.
REQ-021 Row wrap-around: after row ROWS-1, row_sel_o SHALL return to 0 and frame_start_o SHALL pulse with row_load_o.
REQ-022 Row period SHALL be BLANK_CYC+DWELL_CYC cycles, and frame period SHALL be ROWS*(BLANK_CYC+DWELL_CYC) cycles with no gap cycles.
REQ-023 scan_en_i=0 sampled in BLANK or DRIVE SHALL abort: the next cycle SHALL be IDLE with row_sel_o=0, rows inactive, blank_o=1 and no pulses.
REQ-024 Abort SHALL take priority over any same-cycle row-end transition.
REQ-025 After an abort, re-enable SHALL restart at row 0 with a fresh BLANK phase.
REQ-026 Inactive level SHALL be 0 when ACTIVE_LOW=0 and 1 when ACTIVE_LOW=1, for every bit, in every state, including reset.
REQ-027 The shared phase counter SHALL be sized clog2(max(BLANK_CYC, DWELL_CYC)+1) bits and SHALL reload to 0 on every state change.
REQ-028 The counter SHALL NOT overflow and SHALL NOT count while in IDLE.
REQ-029 row_sel_o SHALL never exceed ROWS-1, including when ROWS is not a power of two.

Reset
REQ-030 rst_i=1 sampled SHALL, on the next cycle, force state IDLE, row_sel_o=0, row_onehot_o all inactive, blank_o=1, row_load_o=0, frame_start_o=0 and counter=0.
REQ-031 Reset SHALL override scan_en_i and SHALL take effect mid-BLANK or mid-DRIVE.
REQ-032 After reset is released with scan_en_i=1, the block SHALL start at row 0 as in REQ-016.

Verification (ROWS=8, DWELL_CYC=4, BLANK_CYC=2 unless stated)
REQ-033 Startup: reset, then scan_en_i=1 -> frame_start_o and row_load_o pulse together; 2 cycles blank_o=1; 4 cycles row_onehot_o=8'h01; row_load_o pulses with row_sel_o=1.
REQ-034 Full frame: run 48 cycles -> rows 0..7 each driven exactly 4 cycles in order; the next frame_start_o comes exactly 48 cycles after the first, with row_sel_o=0.
REQ-035 Abort: drop scan_en_i on the 2nd DRIVE cycle of row 5 -> next cycle IDLE, row_onehot_o=8'h00, blank_o=1, row_sel_o=0; re-enable -> frame_start_o with row 0.
REQ-036 Mid-scan reset: assert rst_i during DRIVE of row 3 with scan_en_i held at 1 -> reset values next cycle; after release, restart at row 0.
REQ-037 Polarity and odd size: ROWS=5, ACTIVE_LOW=1 -> idle row_onehot_o=5'b11111; row 4 drive shows 5'b01111; then wraps to row 0; row_sel_o never reaches 5.
REQ-038 Minimum timing: BLANK_CYC=1, DWELL_CYC=1 -> alternating blank_o 1/0 every cycle; row period 2 cycles; frame period 16 cycles.

Source files
------------

// File: rtl/led_row_scan.sv
// Row scanner for a multiplexed LED matrix: cycles IDLE -> BLANK -> DRIVE per row,
// with a registered row index, decoded row drive and load / frame-start pulses.
module led_row_scan #(
    parameter int ROWS       = 8,
    parameter int DWELL_CYC  = 1000,
    parameter int BLANK_CYC  = 16,
    parameter int ACTIVE_LOW = 0,
    localparam int ROW_W     = $clog2(ROWS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scan_en_i,
    output logic [ROW_W-1:0] row_sel_o,
    output logic [ROWS-1:0]  row_onehot_o,
    output logic             blank_o,
    output logic             row_load_o,
    output logic             frame_start_o
);

    localparam int CNT_MAX = (BLANK_CYC > DWELL_CYC) ? BLANK_CYC : DWELL_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic             POL        = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROWS-1:0]    onehot_q, onehot_d;
    logic               blank_q, blank_d;
    logic               load_q, load_d;
    logic               frame_q, frame_d;

    function automatic logic [ROWS-1:0] row_decode(input logic [ROW_W-1:0] r);
        logic [ROWS-1:0] one;
        one        = {{(ROWS-1){1'b0}}, 1'b1};
        row_decode = one << r;
    endfunction

    // Next-state logic; abort on scan_en_i=0 is checked ahead of any row-end transition.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        case (state_q)
            IDLE: begin
                row_d = {ROW_W{1'b0}};
                cnt_d = {CNT_W{1'b0}};
                if (scan_en_i) begin
                    state_d = BLANK;
                    load_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BLANK: begin
                if (!scan_en_i) begin
                    state_d = IDLE;
                    row_d   = {ROW_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DRIVE: begin
                if (!scan_en_i) begin
                    state_d = IDLE;
                    row_d   = {ROW_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == DWELL_LAST) begin
                    state_d = BLANK;
                    cnt_d   = {CNT_W{1'b0}};
                    load_d  = 1'b1;
                    if (row_q == ROW_LAST) begin
                        row_d = {ROW_W{1'b0}};
                    end else begin
                        row_d = row_q + {{(ROW_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = {ROW_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_q.
    always_comb begin
        onehot_d = {ROWS{POL}};
        if (state_d == DRIVE) begin
            onehot_d = row_decode(row_d) ^ {ROWS{POL}};
        end else begin
            onehot_d = {ROWS{POL}};
        end
        blank_d = (state_d != DRIVE);
        frame_d = load_d && (row_d == {ROW_W{1'b0}});
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            row_q    <= {ROW_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            onehot_q <= {ROWS{POL}};
            blank_q  <= 1'b1;
            load_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            blank_q  <= blank_d;
            load_q   <= load_d;
            frame_q  <= frame_d;
        end
    end

    assign row_sel_o     = row_q;
    assign row_onehot_o  = onehot_q;
    assign blank_o       = blank_q;
    assign row_load_o    = load_q;
    assign frame_start_o = frame_q;

endmodule

// File: tb/tb_led_row_scan.sv
// Scoreboard bench for led_row_scan: three configurations share one stimulus stream;
// a time-since-start reference model predicts each cycle, a negedge monitor compares.
module tb_led_row_scan;

    logic clk = 1'b0;
    logic rst_i;
    logic scan_en_i;

    always #5 clk = ~clk;

    // config 0: ROWS=8 D=4 B=2 AL=0 ; config 1: ROWS=5 D=3 B=2 AL=1 ; config 2: ROWS=8 D=1 B=1 AL=0
    logic [2:0] sel0;  logic [7:0] oh0;  logic bl0, ld0, fs0;
    logic [2:0] sel1;  logic [4:0] oh1;  logic bl1, ld1, fs1;
    logic [2:0] sel2;  logic [7:0] oh2;  logic bl2, ld2, fs2;

    led_row_scan #(.ROWS(8), .DWELL_CYC(4), .BLANK_CYC(2), .ACTIVE_LOW(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_i), .scan_en_i(scan_en_i),
        .row_sel_o(sel0), .row_onehot_o(oh0), .blank_o(bl0),
        .row_load_o(ld0), .frame_start_o(fs0));

    led_row_scan #(.ROWS(5), .DWELL_CYC(3), .BLANK_CYC(2), .ACTIVE_LOW(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .scan_en_i(scan_en_i),
        .row_sel_o(sel1), .row_onehot_o(oh1), .blank_o(bl1),
        .row_load_o(ld1), .frame_start_o(fs1));

    led_row_scan #(.ROWS(8), .DWELL_CYC(1), .BLANK_CYC(1), .ACTIVE_LOW(0)) u_dut2 (
        .clk_i(clk), .rst_i(rst_i), .scan_en_i(scan_en_i),
        .row_sel_o(sel2), .row_onehot_o(oh2), .blank_o(bl2),
        .row_load_o(ld2), .frame_start_o(fs2));

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] oh;
        logic        blank;
        logic        load;
        logic        frame;
    } exp_t;

    typedef struct {
        exp_t e[3];
    } cyc_t;

    cyc_t q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int  cfg_rows[3]  = '{8, 5, 8};
    int  cfg_dwell[3] = '{4, 3, 1};
    int  cfg_blank[3] = '{2, 2, 1};
    int  cfg_al[3]    = '{0, 1, 0};

    // Reference model: a scan is either inactive or has run t cycles since its start.
    bit m_active;
    int m_t;

    function automatic exp_t predict(input int c, input bit act, input int t);
        exp_t r;
        int   period, phase, row, mask, drv;
        mask = (1 << cfg_rows[c]) - 1;
        if (!act) begin
            r.sel = 4'd0; drv = 0; r.blank = 1'b1; r.load = 1'b0; r.frame = 1'b0;
        end else begin
            period  = cfg_blank[c] + cfg_dwell[c];
            phase   = t % period;
            row     = (t / period) % cfg_rows[c];
            r.sel   = 4'(row);
            r.blank = (phase < cfg_blank[c]);
            drv     = r.blank ? 0 : (1 << row);
            r.load  = (phase == 0);
            r.frame = (phase == 0) && (row == 0);
        end
        r.oh = 16'((cfg_al[c] != 0) ? (~drv & mask) : drv);
        return r;
    endfunction

    task automatic step(input logic r, input logic e);
        cyc_t cy;
        rst_i     = r;
        scan_en_i = e;
        @(posedge clk);
        if (r) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (!m_active) begin
            if (e) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end else if (!e) begin
            m_active = 1'b0;
            m_t      = 0;
        end else begin
            m_t = m_t + 1;
        end
        for (int c = 0; c < 3; c++) cy.e[c] = predict(c, m_active, m_t);
        q.push_back(cy);
        #1;
    endtask

    task automatic chk(input string name, input int c, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cfg%0d @%0t: got 0x%0h expected 0x%0h", name, c, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUTs present outputs; pop the prediction and compare.
    initial begin
        cyc_t cy;
        exp_t a[3];
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                cy = q.pop_front();
                a[0] = '{sel: 4'(sel0), oh: 16'(oh0), blank: bl0, load: ld0, frame: fs0};
                a[1] = '{sel: 4'(sel1), oh: 16'(oh1), blank: bl1, load: ld1, frame: fs1};
                a[2] = '{sel: 4'(sel2), oh: 16'(oh2), blank: bl2, load: ld2, frame: fs2};
                for (int c = 0; c < 3; c++) begin
                    chk("row_sel",     c, int'(a[c].sel),   int'(cy.e[c].sel));
                    chk("row_onehot",  c, int'(a[c].oh),    int'(cy.e[c].oh));
                    chk("blank",       c, int'(a[c].blank), int'(cy.e[c].blank));
                    chk("row_load",    c, int'(a[c].load),  int'(cy.e[c].load));
                    chk("frame_start", c, int'(a[c].frame), int'(cy.e[c].frame));
                end
            end
        end
    end

    // Stimulus: directed startup / frame / abort / mid-scan reset, then random traffic.
    initial begin
        m_active = 1'b0;
        m_t      = 0;
        repeat (3) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        // startup plus two full frames of config 0
        repeat (100) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        // restart, then abort on the 2nd DRIVE cycle of row 5 (t = 5*6+2+1)
        repeat (34) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        // re-enable, then reset during DRIVE of row 3 with scan_en held high
        repeat (22) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (60) step(1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1);
        end
        step(1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
